// File: rtl/uart_load_ctrl_pkg.sv
// Shared codes for the UART program-reload controller: fetch-control codes,
// loader state encoding and default timing parameters.
package uart_load_ctrl_pkg;

  localparam int HAZD_CTL_WIDTH = 2;
  localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NORMAL = 2'b00;
  localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_RETRY  = 2'b01;
  localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NO_OP  = 2'b10;

  localparam int LOAD_ST_WIDTH = 2;
  typedef enum logic [LOAD_ST_WIDTH-1:0] {
    LOAD_ST_RUN    = 2'd0,
    LOAD_ST_DRAIN  = 2'd1,
    LOAD_ST_LOAD   = 2'd2,
    LOAD_ST_RESUME = 2'd3
  } load_st_e;

  localparam int DEFAULT_ROM_DEPTH      = 14;
  localparam int DEFAULT_DRAIN_CYCLES   = 5;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2**24;
  localparam int DEFAULT_CNT_WIDTH      = 25;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a slow-domain level, with a registered
// rising-edge pulse one cycle after the synchronized level rises.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      level_d <= sync_p1;
      rise    <= sync_p1 & ~level_d;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/uart_load_ctrl.sv
// Sequences a run-time program reload over UART: freeze and drain fetch,
// hand the memories to the UART loader, count words, then restart at PC 0.
module uart_load_ctrl
  import uart_load_ctrl_pkg::*;
#(
  parameter int ROM_DEPTH      = DEFAULT_ROM_DEPTH,
  parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic                      uart_done,
  input  logic                      uart_write_enable,
  input  logic [ROM_DEPTH:0]        uart_addr,
  output logic [HAZD_CTL_WIDTH-1:0] hazard_control,
  output logic                      override,
  output logic                      uart_disable,
  output logic                      uart_rst_n,
  output logic                      pc_reset,
  output logic [ROM_DEPTH:0]        inst_words,
  output logic [ROM_DEPTH:0]        data_words,
  output logic                      load_error,
  output logic                      busy
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  function automatic logic [ROM_DEPTH:0] sat_inc(input logic [ROM_DEPTH:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  load_st_e             state;
  load_st_e             state_nxt;
  logic                 load_req_d;
  logic                 load_rise;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [CNT_WIDTH-1:0] to_cnt;
  logic                 seen_write;
  logic                 timeout_hit;
  logic                 done_lvl;
  logic                 done_rise_unused;
  logic                 wen_level_unused;
  logic                 wen_rise;
  logic [ROM_DEPTH-1:0] addr_low_unused;

  assign addr_low_unused = uart_addr[ROM_DEPTH-1:0];

  sync_edge u_done_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (uart_done),
    .level (done_lvl),
    .rise  (done_rise_unused)
  );

  sync_edge u_wen_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (uart_write_enable),
    .level (wen_level_unused),
    .rise  (wen_rise)
  );

  assign load_rise   = load_req & ~load_req_d;
  // A write in the same cycle counts as activity, so it pre-empts the timeout.
  assign timeout_hit = seen_write && (to_cnt == TO_LAST) && !wen_rise;
  assign busy        = (state != LOAD_ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    override       = 1'b0;
    hazard_control = HAZD_CTL_NORMAL;
    uart_disable   = 1'b1;
    uart_rst_n     = 1'b0;
    pc_reset       = 1'b0;
    case (state)
      LOAD_ST_RUN: begin
        if (load_rise) state_nxt = LOAD_ST_DRAIN;
      end
      LOAD_ST_DRAIN: begin
        override       = 1'b1;
        hazard_control = HAZD_CTL_NO_OP;
        if (drain_cnt == DRAIN_LAST) state_nxt = LOAD_ST_LOAD;
      end
      LOAD_ST_LOAD: begin
        override       = 1'b1;
        hazard_control = HAZD_CTL_RETRY;
        uart_disable   = 1'b0;
        uart_rst_n     = 1'b1;
        if (done_lvl || timeout_hit) state_nxt = LOAD_ST_RESUME;
      end
      LOAD_ST_RESUME: begin
        override       = 1'b1;
        hazard_control = HAZD_CTL_NO_OP;
        pc_reset       = 1'b1;
        state_nxt      = LOAD_ST_RUN;
      end
      default: state_nxt = LOAD_ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_req_d <= 1'b0;
      drain_cnt  <= '0;
      to_cnt     <= '0;
      seen_write <= 1'b0;
      inst_words <= '0;
      data_words <= '0;
      load_error <= 1'b0;
    end else begin
      load_req_d <= load_req;
      case (state)
        LOAD_ST_RUN: begin
          drain_cnt <= '0;
          if (load_rise) begin
            to_cnt     <= '0;
            seen_write <= 1'b0;
            inst_words <= '0;
            data_words <= '0;
            load_error <= 1'b0;
          end
        end
        LOAD_ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        LOAD_ST_LOAD: begin
          if (wen_rise) begin
            if (uart_addr[ROM_DEPTH]) data_words <= sat_inc(data_words);
            else                      inst_words <= sat_inc(inst_words);
            to_cnt     <= '0;
            seen_write <= 1'b1;
          end else if (seen_write) begin
            to_cnt <= to_cnt + 1'b1;
          end
          // A completion seen in the same cycle wins over the timeout.
          if (timeout_hit && !done_lvl) load_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed bench for uart_load_ctrl: drain/load/resume sequencing, word
// counting with saturation, timeout abort, mid-load reset and request edges.
module tb_uart_load_ctrl;
  import uart_load_ctrl_pkg::*;

  localparam int RD = 2;
  localparam int DC = 5;
  localparam int TO = 100;
  localparam int CW = 8;
  localparam int SYNC_LAT = 3;

  typedef struct {
    logic [RD:0] inst;
    logic [RD:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, load_req, uart_done, uart_write_enable;
  logic [RD:0] uart_addr;
  logic [HAZD_CTL_WIDTH-1:0] hazard_control;
  logic override, uart_disable, uart_rst_n, pc_reset, load_error, busy;
  logic [RD:0] inst_words, data_words;

  exp_t sb[$];
  int passed = 0;
  int total = 0;
  int pc_pulses = 0;
  int drain_entries = 0;
  bit prev_drain = 1'b0;

  always #5 clk = ~clk;

  uart_load_ctrl #(
    .ROM_DEPTH(RD), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .uart_done(uart_done),
    .uart_write_enable(uart_write_enable), .uart_addr(uart_addr),
    .hazard_control(hazard_control), .override(override),
    .uart_disable(uart_disable), .uart_rst_n(uart_rst_n), .pc_reset(pc_reset),
    .inst_words(inst_words), .data_words(data_words),
    .load_error(load_error), .busy(busy)
  );

  always @(negedge clk) begin
    bit is_drain;
    is_drain = (busy === 1'b1) && (hazard_control === HAZD_CTL_NO_OP) && (pc_reset === 1'b0);
    if (pc_reset === 1'b1) pc_pulses++;
    if (is_drain && !prev_drain) drain_entries++;
    prev_drain = is_drain;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_override"}, override, 0);
    check({tag, "_hazard"}, hazard_control, HAZD_CTL_NORMAL);
    check({tag, "_uart_disable"}, uart_disable, 1);
    check({tag, "_uart_rst_n"}, uart_rst_n, 0);
    check({tag, "_pc_reset"}, pc_reset, 0);
    check({tag, "_inst_words"}, inst_words, 0);
    check({tag, "_data_words"}, data_words, 0);
    check({tag, "_load_error"}, load_error, 0);
  endtask

  task automatic uart_write(input logic [RD:0] addr);
    uart_addr = addr;
    uart_write_enable = 1'b1;
    repeat (6) @(negedge clk);
    uart_write_enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (uart_disable !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_enter_load"}, uart_disable, 0);
  endtask

  task automatic wait_resume(input string tag);
    int n = 0;
    exp_t e;
    while (pc_reset !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pc_reset_seen"}, pc_reset, 1);
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_inst_words"}, inst_words, e.inst);
      check({tag, "_data_words"}, data_words, e.data);
      check({tag, "_load_error"}, load_error, e.err);
    end
    @(negedge clk);
    check({tag, "_pulse_one_cycle"}, pc_reset, 0);
    check({tag, "_back_to_run"}, busy, 0);
    check({tag, "_run_hazard"}, hazard_control, HAZD_CTL_NORMAL);
    check({tag, "_run_override"}, override, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    bit drain_ok;
    exp_t e;

    rst = 1'b1; load_req = 1'b0; uart_done = 1'b0;
    uart_write_enable = 1'b0; uart_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    base = pc_pulses;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_uart_disable", uart_disable, 1);
    check("idle_no_pc_reset", pc_pulses - base, 0);

    uart_done = 1'b1;
    repeat (10) @(negedge clk);
    check("done_in_run_busy", busy, 0);
    uart_done = 1'b0;
    repeat (5) @(negedge clk);

    // Normal load: drain length, load outputs, counts on completion.
    load_req = 1'b1;
    @(negedge clk);
    n = 0; drain_ok = 1'b1;
    while (busy === 1'b1 && hazard_control === HAZD_CTL_NO_OP && pc_reset === 1'b0 && n < 20) begin
      if (uart_disable !== 1'b1 || uart_rst_n !== 1'b0 || override !== 1'b1) drain_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("drain_cycles", n, DC);
    check("drain_outputs", drain_ok, 1);
    check("load_hazard", hazard_control, HAZD_CTL_RETRY);
    check("load_uart_disable", uart_disable, 0);
    check("load_uart_rst_n", uart_rst_n, 1);
    check("load_override", override, 1);
    load_req = 1'b0;
    e.inst = 3'd3; e.data = 3'd2; e.err = 1'b0;
    sb.push_back(e);
    uart_write(3'd0); uart_write(3'd1); uart_write(3'd2);
    uart_write(3'd4); uart_write(3'd5);
    uart_done = 1'b1;
    wait_resume("normal");
    uart_done = 1'b0;
    repeat (5) @(negedge clk);

    // Timeout: a single write then silence.
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wait_load("timeout");
    e.inst = 3'd1; e.data = 3'd0; e.err = 1'b1;
    sb.push_back(e);
    uart_addr = 3'd0;
    uart_write_enable = 1'b1;
    n = 0;
    while (pc_reset !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 6) uart_write_enable = 1'b0;
    end
    check("timeout_latency", n, SYNC_LAT + 1 + TO);
    wait_resume("timeout");
    repeat (5) @(negedge clk);

    // Reset in the middle of a load.
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wait_load("midrst");
    uart_write(3'd0); uart_write(3'd1);
    check("midrst_live_inst", inst_words, 2);
    base = pc_pulses;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_pc_reset", pc_pulses - base, 0);
    check("midrst_idle", busy, 0);

    // Request held high across a load and re-pulsed during LOAD; data saturates.
    base = drain_entries;
    load_req = 1'b1;
    wait_load("held");
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    load_req = 1'b1;
    repeat (3) @(negedge clk);
    check("held_pulse_stays_load", hazard_control, HAZD_CTL_RETRY);
    e.inst = 3'd1; e.data = 3'd7; e.err = 1'b0;
    sb.push_back(e);
    uart_write(3'd0);
    for (int i = 0; i < 9; i++) uart_write(3'(4 + (i % 4)));
    uart_done = 1'b1;
    wait_resume("held");
    uart_done = 1'b0;
    repeat (30) @(negedge clk);
    check("held_no_retrigger", busy, 0);
    check("held_single_drain", drain_entries - base, 1);
    load_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_load_ctrl.md
Name: uart_load_ctrl

Overview:
- Sequences run-time program reloads over UART for the pipelined CPU.
- On an operator request it:
  - freezes instruction fetch and drains the pipeline;
  - hands instruction/data memory ports to the UART loader;
  - counts the words written;
  - on completion or timeout, resets PC to 0 and resumes execution.
- Sits beside hazard_unit. Its outputs override hazard_unit's fetch control whenever it is not in RUN.

Parameters:
- ROM_DEPTH, `DEFAULT_ROM_DEPTH: word-address width of each memory half; UART address is ROM_DEPTH+1 bits.
- DRAIN_CYCLES, 5: NO_OP cycles issued before granting UART (pipeline depth).
- TIMEOUT_CYCLES, 2**24: idle clk cycles after the first write before a load is aborted.
- CNT_WIDTH, 25: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  operator request (debounced button), level.
- uart_done  in  1  upg_done_o from uart_unit (uart_clk domain, level).
- uart_write_enable  in  1  upg_wen_i (uart_clk domain, level).
- uart_addr  in  ROM_DEPTH+1  upg_adr_i; MSB 0 = instruction half, 1 = data half.
- hazard_control  out  `HAZD_CTL_WIDTH  fetch control when override=1.
- override  out  1  1 = hazard_control here supersedes hazard_unit's.
- uart_disable  out  1  0 = memories clocked/addressed by UART.
- uart_rst_n  out  1  active-low reset to uart_unit.
- pc_reset  out  1  one-cycle pulse to instruction_mem.
- inst_words  out  ROM_DEPTH+1  instruction words written in last load.
- data_words  out  ROM_DEPTH+1  data words written in last load.
- load_error  out  1  last load ended by timeout.
- busy  out  1  state != RUN (LED).

Behaviour:
- Reset values:
  - RUN; override=0; hazard_control=`HAZD_CTL_NORMAL; uart_disable=1; uart_rst_n=0; pc_reset=0.
  - Counters, load_error and busy = 0. Synchronizer flops = 0.
- Synchronization:
  - uart_done and uart_write_enable each pass through a 2-flop synchronizer.
  - A write is counted on the rising edge of the synchronized wen; uart_addr is sampled on that same cycle.
  - The 3-cycle sync latency is acceptable because uart_clk is much slower than clk.
- FSM:
  - RUN:
    - Outputs idle; uart_rst_n=0.
    - Rising edge of load_req -> DRAIN. A held level does not retrigger.
  - DRAIN:
    - override=1, hazard_control=`HAZD_CTL_NO_OP, uart_disable=1.
    - Drain counter counts DRAIN_CYCLES cycles, then -> LOAD.
    - On entry, clear inst_words, data_words, load_error and the timeout counter.
  - LOAD:
    - override=1, hazard_control=`HAZD_CTL_RETRY (PC frozen), uart_disable=0, uart_rst_n=1.
    - Each counted write: addr MSB 0 increments inst_words, otherwise data_words. Both saturate at all-ones.
    - Timeout counter is held at 0 until the first write. After that it increments every cycle and clears on each write.
    - Exits:
      - Synchronized uart_done=1 -> RESUME.
      - Timeout counter reaches TIMEOUT_CYCLES-1 -> load_error=1, then -> RESUME.
      - uart_done and the final write edge in the same cycle: count the write first, then exit to RESUME.
  - RESUME:
    - One cycle: override=1, hazard_control=`HAZD_CTL_NO_OP, uart_disable=1, uart_rst_n=0, pc_reset=1.
    - Next cycle -> RUN; first fetch is address 0 on that cycle.
- load_req edges outside RUN are ignored. They are not queued.
- rst in any state forces reset values on the next edge, including mid-LOAD. The partial load is discarded and no pc_reset is issued.
- uart_done asserted in RUN or DRAIN: no effect, since uart_unit is held in reset.

Decomposition:
- Add to definitions.v:
  - LOAD_ST_WIDTH (2) and LOAD_ST_RUN/DRAIN/LOAD/RESUME state codes;
  - default macros for DRAIN_CYCLES and TIMEOUT_CYCLES.
- Reuse the existing `HAZD_CTL_* codes.
- One sub-module: sync_edge. It is a 2-flop synchronizer with registered rising-edge output, instantiated twice.

Test Plan:
- Reset, then idle 20 cycles -> busy=0, override=0, uart_disable=1, uart_rst_n=0, pc_reset never 1.
- load_req 0->1 -> exactly 5 cycles of NO_OP with uart_disable=1, then LOAD with uart_disable=0, uart_rst_n=1, RETRY.
- In LOAD, 3 writes at addr 0x0000-0x0002 and 2 writes with MSB=1, then uart_done -> inst_words=3, data_words=2, load_error=0. RESUME pulses pc_reset for 1 cycle, then RUN.
- One write then silence, with TIMEOUT_CYCLES=100 -> RESUME 100 cycles after the write, load_error=1, pc_reset pulse.
- rst asserted 2 writes into LOAD -> next cycle all reset values, no pc_reset pulse.
- load_req held high across a whole load, and pulsed again during LOAD -> exactly one load sequence and no re-entry to DRAIN.
